axi_b_stream_tap: RTL and testbench



---
 rtl/eth_helper_pkg.sv | 8 +
 rtl/b_rec_fifo.sv | 32 +++
 rtl/axi_b_stream_tap.sv | 82 ++++++++
 tb/tb_axi_b_stream_tap.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/eth_helper_pkg.sv
// eth_helper_pkg: shared types and helpers for the Ethernet helper channel taps
package eth_helper_pkg;
  typedef enum logic [1:0] {OKAY = 2'd0, EXOKAY = 2'd1, SLVERR = 2'd2, DECERR = 2'd3} bresp_t;
  localparam int SEQ_W = 16;
  function automatic int beats(input int rec_w, input int data_w);
    return (rec_w + data_w - 1) / data_w;
  endfunction
endpackage

// File: rtl/b_rec_fifo.sv
// b_rec_fifo: first-word-fall-through record FIFO with async active-high reset
module b_rec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  // extra pointer bit separates full from empty when the indices coincide
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/axi_b_stream_tap.sv
// axi_b_stream_tap: forwards AXI B beats and serialises a record of each onto the helper stream
module axi_b_stream_tap
  import eth_helper_pkg::*;
#(
  parameter int DATA_WIDTH       = 128,
  parameter int ID_WIDTH         = 32,
  parameter int USER_WIDTH       = 64,
  parameter int FIFO_DEPTH       = 8,
  parameter int DROP_ON_FULL     = 1,
  parameter int CAPTURE_ERR_ONLY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  output logic                  valid,
  output logic                  in_progress,
  output logic [DATA_WIDTH-1:0] data,
  output logic [15:0]           drop_count,
  output logic [ID_WIDTH-1:0]   AXIM_bid,
  output logic [1:0]            AXIM_bresp,
  output logic [USER_WIDTH-1:0] AXIM_buser,
  output logic                  AXIM_bvalid,
  input  logic                  AXIM_bready,
  input  logic [ID_WIDTH-1:0]   AXIS_bid,
  input  logic [1:0]            AXIS_bresp,
  input  logic [USER_WIDTH-1:0] AXIS_buser,
  input  logic                  AXIS_bvalid,
  output logic                  AXIS_bready
);
  localparam int REC_W = 18 + ID_WIDTH + USER_WIDTH;
  localparam int BEATS = beats(REC_W, DATA_WIDTH);
  localparam int PAD_W = BEATS * DATA_WIDTH;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [0:0] IDLE = 1'b0, SEND = 1'b1;
  logic [0:0]       state;
  logic [BW-1:0]    bidx;
  logic [SEQ_W-1:0] seq;
  logic             full, empty, stall, hs, elig, push, drop, fire, last, pop;
  logic [PAD_W-1:0] rec, head;
  assign stall       = (DROP_ON_FULL == 0) && full;
  assign AXIM_bid    = AXIS_bid;
  assign AXIM_bresp  = AXIS_bresp;
  assign AXIM_buser  = AXIS_buser;
  assign AXIM_bvalid = !reset && AXIS_bvalid && !stall;
  assign AXIS_bready = !reset && AXIM_bready && !stall;
  assign hs          = AXIS_bvalid && AXIS_bready;
  assign elig        = hs && (CAPTURE_ERR_ONLY == 0 || AXIS_bresp != OKAY);
  // fullness is the pre-edge count, so a push meeting a same-cycle pop still drops
  assign push        = elig && !full;
  assign drop        = elig && full;
  assign valid       = state == SEND || !empty;
  assign fire        = valid && ready;
  assign last        = bidx == BW'(BEATS - 1);
  assign pop         = fire && last;
  assign in_progress = state == SEND || fire;
  assign data        = empty ? '0 : head[bidx*DATA_WIDTH +: DATA_WIDTH];
  assign rec         = PAD_W'({seq, AXIS_buser, AXIS_bid, AXIS_bresp});
  b_rec_fifo #(.WIDTH(PAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (push),
    .pop  (pop),
    .din  (rec),
    .full (full),
    .empty(empty),
    .head (head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      bidx       <= '0;
      seq        <= '0;
      drop_count <= '0;
    end else begin
      if (elig) seq <= seq + SEQ_W'(1);
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (fire) begin
        bidx  <= last ? '0 : bidx + BW'(1);
        state <= last ? IDLE : SEND;
      end
    end
endmodule

// File: tb/tb_axi_b_stream_tap.sv
// tb_axi_b_stream_tap: three tap configurations driven together against a queue-level reference model
module tb_axi_b_stream_tap;
  logic        clk = 1'b0;
  logic        reset, ready, AXIS_bvalid, AXIM_bready;
  logic [31:0] AXIS_bid;
  logic [1:0]  AXIS_bresp;
  logic [63:0] AXIS_buser;
  logic        valid_o [3];
  logic        inp_o   [3];
  logic        mbv     [3];
  logic        sbr     [3];
  logic [15:0] dc_o    [3];
  logic [31:0] mbid    [3];
  logic [1:0]  mbresp  [3];
  logic [63:0] mbuser  [3];
  logic [63:0] da, db;
  logic [127:0] dcc;
  int compared = 0, mismatched = 0;
  logic [127:0] mem [3][4];
  int cnt [3], pos [3], drops [3];
  logic [15:0] seq [3];

  always #5 clk = ~clk;

  // instance 0: two beats, depth 2, drop on full
  axi_b_stream_tap #(.DATA_WIDTH(64), .FIFO_DEPTH(2), .DROP_ON_FULL(1), .CAPTURE_ERR_ONLY(0)) dut_a (
    .clk(clk), .reset(reset), .ready(ready), .valid(valid_o[0]), .in_progress(inp_o[0]),
    .data(da), .drop_count(dc_o[0]), .AXIM_bid(mbid[0]), .AXIM_bresp(mbresp[0]),
    .AXIM_buser(mbuser[0]), .AXIM_bvalid(mbv[0]), .AXIM_bready(AXIM_bready),
    .AXIS_bid(AXIS_bid), .AXIS_bresp(AXIS_bresp), .AXIS_buser(AXIS_buser),
    .AXIS_bvalid(AXIS_bvalid), .AXIS_bready(sbr[0]));
  // instance 1: two beats, depth 4, backpressure
  axi_b_stream_tap #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .DROP_ON_FULL(0), .CAPTURE_ERR_ONLY(0)) dut_b (
    .clk(clk), .reset(reset), .ready(ready), .valid(valid_o[1]), .in_progress(inp_o[1]),
    .data(db), .drop_count(dc_o[1]), .AXIM_bid(mbid[1]), .AXIM_bresp(mbresp[1]),
    .AXIM_buser(mbuser[1]), .AXIM_bvalid(mbv[1]), .AXIM_bready(AXIM_bready),
    .AXIS_bid(AXIS_bid), .AXIS_bresp(AXIS_bresp), .AXIS_buser(AXIS_buser),
    .AXIS_bvalid(AXIS_bvalid), .AXIS_bready(sbr[1]));
  // instance 2: single beat, depth 2, backpressure, errors only
  axi_b_stream_tap #(.DATA_WIDTH(128), .FIFO_DEPTH(2), .DROP_ON_FULL(0), .CAPTURE_ERR_ONLY(1)) dut_c (
    .clk(clk), .reset(reset), .ready(ready), .valid(valid_o[2]), .in_progress(inp_o[2]),
    .data(dcc), .drop_count(dc_o[2]), .AXIM_bid(mbid[2]), .AXIM_bresp(mbresp[2]),
    .AXIM_buser(mbuser[2]), .AXIM_bvalid(mbv[2]), .AXIM_bready(AXIM_bready),
    .AXIS_bid(AXIS_bid), .AXIS_bresp(AXIS_bresp), .AXIS_buser(AXIS_buser),
    .AXIS_bvalid(AXIS_bvalid), .AXIS_bready(sbr[2]));

  function automatic int dw(input int i); return i == 2 ? 128 : 64; endfunction
  function automatic int depth(input int i); return i == 1 ? 4 : 2; endfunction
  function automatic bit drop_mode(input int i); return i == 0; endfunction
  function automatic bit err_only(input int i); return i == 2; endfunction
  function automatic int nbeats(input int i); return (114 + dw(i) - 1) / dw(i); endfunction
  function automatic bit stall_e(input int i); return !drop_mode(i) && cnt[i] == depth(i); endfunction
  function automatic bit bready_e(input int i); return !reset && AXIM_bready && !stall_e(i); endfunction
  function automatic bit bvalid_e(input int i); return !reset && AXIS_bvalid && !stall_e(i); endfunction
  function automatic logic [127:0] data_e(input int i);
    logic [127:0] s;
    if (cnt[i] == 0) return '0;
    s = mem[i][0] >> (pos[i] * dw(i));
    if (dw(i) == 64) s[127:64] = '0;
    return s;
  endfunction
  function automatic logic [127:0] data_a(input int i);
    return i == 0 ? {64'b0, da} : i == 1 ? {64'b0, db} : dcc;
  endfunction

  task automatic chk(input string tag, input int i, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s[%0d] got %h expected %h", tag, i, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0; pos[i] = 0; drops[i] = 0; seq[i] = '0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("valid", i, 128'(valid_o[i]), 128'(cnt[i] > 0));
      chk("in_progress", i, 128'(inp_o[i]), 128'(pos[i] != 0 || (cnt[i] > 0 && ready)));
      chk("data", i, data_a(i), data_e(i));
      chk("drop_count", i, 128'(dc_o[i]), 128'(drops[i]));
      chk("AXIS_bready", i, 128'(sbr[i]), 128'(bready_e(i)));
      chk("AXIM_bvalid", i, 128'(mbv[i]), 128'(bvalid_e(i)));
      chk("AXIM_fwd", i, {mbuser[i], mbid[i], 30'b0, mbresp[i]}, {AXIS_buser, AXIS_bid, 30'b0, AXIS_bresp});
    end
  endtask

  task automatic update();
    for (int i = 0; i < 3; i++) begin
      bit full, hs, el, fire, popv;
      logic [127:0] r;
      if (reset) begin
        cnt[i] = 0; pos[i] = 0; drops[i] = 0; seq[i] = '0;
        continue;
      end
      full = cnt[i] == depth(i);
      hs   = AXIS_bvalid && bready_e(i);
      el   = hs && (!err_only(i) || AXIS_bresp != 2'd0);
      fire = cnt[i] > 0 && ready;
      popv = fire && pos[i] == nbeats(i) - 1;
      r    = 128'({seq[i], AXIS_buser, AXIS_bid, AXIS_bresp});
      if (fire) pos[i] = popv ? 0 : pos[i] + 1;
      if (popv) begin
        for (int k = 0; k < 3; k++) mem[i][k] = mem[i][k+1];
        cnt[i]--;
      end
      if (el && !full) begin
        mem[i][cnt[i]] = r;
        cnt[i]++;
      end
      if (el && full && drops[i] < 65535) drops[i]++;
      if (el) seq[i]++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update();
    #1;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b0; AXIS_bvalid = 1'b0; AXIM_bready = 1'b0;
    AXIS_bid = '0; AXIS_bresp = '0; AXIS_buser = '0;
    model_clear();
    repeat (2) cycle();
    reset = 1'b0;
    ready = 1'b1; AXIM_bready = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      AXIS_bvalid = 1'b1; AXIS_bid = 32'(b); AXIS_bresp = 2'd0; AXIS_buser = 64'hA0 + 64'(b);
      cycle();
    end
    AXIS_bvalid = 1'b0;
    repeat (6) cycle();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      AXIS_bvalid = 1'b1; AXIS_bid = $urandom; AXIS_bresp = 2'(k % 4); AXIS_buser = {$urandom, $urandom};
      cycle();
    end
    AXIS_bvalid = 1'b0;
    cycle();
    for (int k = 0; k < 12; k++) begin
      ready = (k % 3) != 1;
      cycle();
    end
    repeat (400) begin
      ready = 1'($urandom_range(0, 1)); AXIS_bvalid = 1'($urandom_range(0, 1));
      AXIM_bready = $urandom_range(0, 3) != 0;
      AXIS_bid = $urandom; AXIS_bresp = 2'($urandom_range(0, 3)); AXIS_buser = {$urandom, $urandom};
      cycle();
    end
    AXIM_bready = 1'b1; ready = 1'b0; AXIS_bvalid = 1'b1; AXIS_bresp = 2'd3;
    repeat (3) cycle();
    AXIS_bvalid = 1'b0; ready = 1'b1;
    cycle();
    ready = 1'b0; reset = 1'b1;
    model_clear();
    repeat (2) cycle();
    reset = 1'b0;
    AXIS_bvalid = 1'b1; AXIS_bresp = 2'd2; AXIS_bid = 32'd7;
    cycle();
    AXIS_bvalid = 1'b0; ready = 1'b1;
    repeat (6) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
